// File: rtl/down_count_monitor_pkg.sv
// rtl/down_count_monitor_pkg.sv - shared types and constants for the down-counter monitor
package down_count_monitor_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    TRACK = 2'd1,
    STALL = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    EVT_NONE  = 2'b00,
    EVT_WRAP  = 2'b01,
    EVT_SKIP  = 2'b10,
    EVT_STALL = 2'b11
  } evt_type_t;

  // Next value a healthy down counter must present; wraps 0 -> 15.
  function automatic logic [CNT_W-1:0] expected_next(input logic [CNT_W-1:0] v);
    return v - 1'b1;
  endfunction

endpackage

// File: rtl/dcm_evt_slot.sv
// rtl/dcm_evt_slot.sv - single-entry registered event slot with valid/ready handoff
module dcm_evt_slot
  import down_count_monitor_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  evt_type_t        load_type,
  input  logic [CNT_W-1:0] load_data,
  input  logic             evt_ready,
  output logic             evt_valid,
  output logic [1:0]       evt_type,
  output logic [CNT_W-1:0] evt_data,
  output logic             drop
);

  // An event arriving while the slot is full and not draining is lost.
  assign drop = load & evt_valid & ~evt_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      evt_valid <= 1'b0;
      evt_type  <= 2'b00;
      evt_data  <= '0;
    end else if (clr) begin
      evt_valid <= 1'b0;
      evt_type  <= 2'b00;
      evt_data  <= '0;
    end else if (load && (!evt_valid || evt_ready)) begin
      evt_valid <= 1'b1;
      evt_type  <= load_type;
      evt_data  <= load_data;
    end else if (evt_ready) begin
      evt_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/down_count_monitor.sv
// rtl/down_count_monitor.sv - checks a 4-bit down counter for wraps, skips and stalls; DCM_ERRCNT_EN adds err_cnt
module down_count_monitor
  import down_count_monitor_pkg::*;
#(
  parameter int WRAP_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CNT_W-1:0]  cnt_q,
  input  logic              cnt_vld,
  input  logic              clr,
  input  logic              evt_ready,
  output logic              evt_valid,
  output logic [1:0]        evt_type,
  output logic [CNT_W-1:0]  evt_data,
  output logic [WRAP_W-1:0] wrap_cnt,
  output logic              err,
  output logic              ovf,
  output logic [7:0]        err_cnt
);

  state_t           state, state_n;
  logic [CNT_W-1:0] prev, prev_n;
  logic [CNT_W-1:0] exp_val;
  logic             ev_fire;
  evt_type_t        ev_type;
  logic [CNT_W-1:0] ev_data;
  logic             is_wrap, is_skip;
  logic             drop;

  assign exp_val = expected_next(prev);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= SYNC;
      prev  <= '0;
    end else begin
      state <= state_n;
      prev  <= prev_n;
    end
  end

  always_comb begin
    state_n = state;
    prev_n  = prev;
    ev_fire = 1'b0;
    ev_type = EVT_NONE;
    ev_data = '0;
    is_wrap = 1'b0;
    is_skip = 1'b0;
    if (clr) begin
      state_n = SYNC;
    end else if (cnt_vld) begin
      case (state)
        SYNC: begin
          prev_n  = cnt_q;
          state_n = TRACK;
        end
        TRACK, STALL: begin
          if (cnt_q == exp_val) begin
            prev_n  = cnt_q;
            state_n = TRACK;
            if (prev == '0) begin
              is_wrap = 1'b1;
              ev_fire = 1'b1;
              ev_type = EVT_WRAP;
              ev_data = '1;
            end
          end else if (cnt_q == prev) begin
            // Only the first repeated sample reports; further repeats are silent.
            if (state == TRACK) begin
              ev_fire = 1'b1;
              ev_type = EVT_STALL;
              ev_data = cnt_q;
              state_n = STALL;
            end
          end else begin
            is_skip = 1'b1;
            ev_fire = 1'b1;
            ev_type = EVT_SKIP;
            ev_data = cnt_q;
            prev_n  = cnt_q;
            state_n = TRACK;
          end
        end
        default: state_n = SYNC;
      endcase
    end
  end

  dcm_evt_slot u_slot (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .load      (ev_fire),
    .load_type (ev_type),
    .load_data (ev_data),
    .evt_ready (evt_ready),
    .evt_valid (evt_valid),
    .evt_type  (evt_type),
    .evt_data  (evt_data),
    .drop      (drop)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrap_cnt <= '0;
      err      <= 1'b0;
      ovf      <= 1'b0;
    end else if (clr) begin
      wrap_cnt <= '0;
      err      <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      if (is_wrap && (wrap_cnt != '1))
        wrap_cnt <= wrap_cnt + WRAP_W'(1);
      if (is_skip)
        err <= 1'b1;
      if (drop)
        ovf <= 1'b1;
    end
  end

`ifdef DCM_ERRCNT_EN
  logic [7:0] err_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      err_cnt_q <= 8'd0;
    else if (clr)
      err_cnt_q <= 8'd0;
    else if (is_skip && (err_cnt_q != 8'hFF))
      err_cnt_q <= err_cnt_q + 8'd1;
  end

  assign err_cnt = err_cnt_q;
`else
  assign err_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_down_count_monitor.sv
// tb/tb_down_count_monitor.sv - self-checking bench for down_count_monitor
module tb_down_count_monitor;

  localparam int WRAP_W   = 8;
  localparam int WRAP_MAX = (1 << WRAP_W) - 1;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [3:0]        cnt_q = 4'd0;
  logic              cnt_vld = 1'b0;
  logic              clr = 1'b0;
  logic              evt_ready = 1'b0;
  logic              evt_valid;
  logic [1:0]        evt_type;
  logic [3:0]        evt_data;
  logic [WRAP_W-1:0] wrap_cnt;
  logic              err;
  logic              ovf;
  logic [7:0]        err_cnt;

  always #5 clk = ~clk;

  down_count_monitor #(.WRAP_W(WRAP_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .cnt_q     (cnt_q),
    .cnt_vld   (cnt_vld),
    .clr       (clr),
    .evt_ready (evt_ready),
    .evt_valid (evt_valid),
    .evt_type  (evt_type),
    .evt_data  (evt_data),
    .wrap_cnt  (wrap_cnt),
    .err       (err),
    .ovf       (ovf),
    .err_cnt   (err_cnt)
  );

  // Reference model: tracks the last accepted counter value and whether a
  // repeat was already reported, plus a one-deep event holding area.
  int m_synced, m_last, m_repeat;
  int m_valid, m_type, m_data;
  int m_wrap, m_err, m_ovf, m_errcnt;
  int have_ev, ev_t, ev_d, drained;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_synced = 0; m_last = 0; m_repeat = 0;
      m_valid = 0; m_type = 0; m_data = 0;
      m_wrap = 0; m_err = 0; m_ovf = 0; m_errcnt = 0;
    end else if (clr) begin
      m_synced = 0; m_repeat = 0;
      m_valid = 0; m_type = 0; m_data = 0;
      m_wrap = 0; m_err = 0; m_ovf = 0; m_errcnt = 0;
    end else begin
      have_ev = 0; ev_t = 0; ev_d = 0;
      drained = (m_valid != 0) && evt_ready;
      if (cnt_vld) begin
        if (m_synced == 0) begin
          m_synced = 1; m_last = int'(cnt_q); m_repeat = 0;
        end else if (int'(cnt_q) == (m_last + 15) % 16) begin
          if (m_last == 0) begin
            have_ev = 1; ev_t = 1; ev_d = 15;
            if (m_wrap < WRAP_MAX) m_wrap = m_wrap + 1;
          end
          m_last = int'(cnt_q); m_repeat = 0;
        end else if (int'(cnt_q) == m_last) begin
          if (m_repeat == 0) begin
            have_ev = 1; ev_t = 3; ev_d = m_last;
          end
          m_repeat = 1;
        end else begin
          have_ev = 1; ev_t = 2; ev_d = int'(cnt_q);
          m_err = 1;
`ifdef DCM_ERRCNT_EN
          if (m_errcnt < 255) m_errcnt = m_errcnt + 1;
`endif
          m_last = int'(cnt_q); m_repeat = 0;
        end
      end
      if (drained) m_valid = 0;
      if (have_ev != 0) begin
        if (m_valid == 0) begin
          m_valid = 1; m_type = ev_t; m_data = ev_d;
        end else begin
          m_ovf = 1;
        end
      end
    end
  end

  int pass_cnt = 0;
  int chk_cnt  = 0;
  int n_xfer = 0, n_wrap = 0, n_skip = 0, n_stall = 0, last_data = 0;

  task automatic check(input string name, input int act, input int exp_v);
    chk_cnt++;
    if (act == exp_v) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
  endtask

  task automatic compare_cycle();
    check("evt_valid", int'(evt_valid), m_valid);
    if (m_valid != 0) begin
      check("evt_type", int'(evt_type), m_type);
      check("evt_data", int'(evt_data), m_data);
    end
    check("wrap_cnt", int'(wrap_cnt), m_wrap);
    check("err", int'(err), m_err);
    check("ovf", int'(ovf), m_ovf);
    check("err_cnt", int'(err_cnt), m_errcnt);
  endtask

  // Apply one cycle of input, note any handshake the DUT completes, then compare.
  task automatic step(input logic v, input logic [3:0] q);
    cnt_vld = v;
    cnt_q   = q;
    if (evt_valid && evt_ready) begin
      n_xfer++;
      last_data = int'(evt_data);
      case (evt_type)
        2'b01:   n_wrap++;
        2'b10:   n_skip++;
        2'b11:   n_stall++;
        default: ;
      endcase
    end
    @(posedge clk);
    @(negedge clk);
    compare_cycle();
  endtask

  task automatic do_clear();
    clr = 1'b1;
    step(1'b0, 4'd0);
    clr = 1'b0;
  endtask

  initial begin
    int seq33[6];
    int x0, w0, s0, t0, q;
    seq33 = '{3, 2, 1, 0, 15, 14};

    repeat (2) @(negedge clk);
    compare_cycle();
    check("rst_evt_valid", int'(evt_valid), 0);
    check("rst_wrap_cnt", int'(wrap_cnt), 0);
    check("rst_err", int'(err), 0);
    check("rst_ovf", int'(ovf), 0);
    rst = 1'b1;
    evt_ready = 1'b1;

    // Single wrap across 0 -> 15
    x0 = n_xfer; w0 = n_wrap;
    foreach (seq33[i]) step(1'b1, 4'(seq33[i]));
    step(1'b0, 4'd0);
    step(1'b0, 4'd0);
    check("wrap_events", n_wrap - w0, 1);
    check("wrap_xfers", n_xfer - x0, 1);
    check("wrap_data", last_data, 15);
    check("wrap_cnt_1", int'(wrap_cnt), 1);
    check("wrap_err_0", int'(err), 0);

    // Skip 5 -> 2, then 1 follows 2 correctly
    do_clear();
    x0 = n_xfer; s0 = n_skip;
    step(1'b1, 4'd5);
    step(1'b1, 4'd2);
    step(1'b1, 4'd1);
    step(1'b0, 4'd0);
    check("skip_events", n_skip - s0, 1);
    check("skip_xfers", n_xfer - x0, 1);
    check("skip_data", last_data, 2);
    check("skip_err", int'(err), 1);

    // Stall 7,7,7 then resume at 6; later repeat proves return to tracking
    do_clear();
    x0 = n_xfer; t0 = n_stall;
    step(1'b1, 4'd7);
    step(1'b1, 4'd7);
    step(1'b1, 4'd7);
    step(1'b1, 4'd6);
    step(1'b0, 4'd0);
    check("stall_events", n_stall - t0, 1);
    check("stall_xfers", n_xfer - x0, 1);
    check("stall_data", last_data, 7);
    step(1'b1, 4'd5);
    step(1'b1, 4'd5);
    step(1'b0, 4'd0);
    check("stall_again", n_stall - t0, 2);
    check("stall_again_data", last_data, 5);

    // Backpressure: WRAP held, following SKIP dropped
    do_clear();
    evt_ready = 1'b0;
    step(1'b1, 4'd1);
    step(1'b1, 4'd0);
    step(1'b1, 4'd15);
    step(1'b1, 4'd3);
    check("bp_valid", int'(evt_valid), 1);
    check("bp_type", int'(evt_type), 1);
    check("bp_data", int'(evt_data), 15);
    check("bp_ovf", int'(ovf), 1);
    evt_ready = 1'b1;
    x0 = n_xfer; w0 = n_wrap;
    step(1'b0, 4'd0);
    step(1'b0, 4'd0);
    step(1'b0, 4'd0);
    check("bp_wrap_once", n_wrap - w0, 1);
    check("bp_xfer_once", n_xfer - x0, 1);
    check("bp_drained", int'(evt_valid), 0);

    // 300 skips: err_cnt saturates when built in
    do_clear();
    s0 = n_skip;
    q = 0;
    step(1'b1, 4'd0);
    for (int i = 0; i < 300; i++) begin
      q = (q + 2) % 16;
      step(1'b1, 4'(q));
    end
    step(1'b0, 4'd0);
    check("skip300_xfers", n_skip - s0, 300);
    check("skip300_ovf", int'(ovf), 0);
`ifdef DCM_ERRCNT_EN
    check("err_cnt_sat", int'(err_cnt), 255);
`else
    check("err_cnt_off", int'(err_cnt), 0);
`endif

    // 260 wraps: wrap_cnt saturates at all-ones
    do_clear();
    w0 = n_wrap;
    step(1'b1, 4'd0);
    for (int n = 0; n < 260; n++)
      for (int k = 15; k >= 0; k--) step(1'b1, 4'(k));
    step(1'b0, 4'd0);
    check("wrap260_events", n_wrap - w0, 260);
    check("wrap_cnt_sat", int'(wrap_cnt), WRAP_MAX);

    // Async reset while an event is pending
    do_clear();
    evt_ready = 1'b0;
    step(1'b1, 4'd2);
    step(1'b1, 4'd5);
    check("pre_rst_valid", int'(evt_valid), 1);
    rst = 1'b0;
    #1;
    check("async_rst_valid", int'(evt_valid), 0);
    check("async_rst_err", int'(err), 0);
    step(1'b0, 4'd0);
    step(1'b0, 4'd0);
    rst = 1'b1;
    evt_ready = 1'b1;
    x0 = n_xfer;
    step(1'b1, 4'd9);
    step(1'b1, 4'd8);
    step(1'b0, 4'd0);
    check("post_rst_sync_only", n_xfer - x0, 0);

    // clr wins over a sample in the same cycle
    step(1'b1, 4'd5);
    check("pre_clr_err", int'(err), 1);
    clr = 1'b1;
    step(1'b1, 4'd12);
    clr = 1'b0;
    check("clr_err", int'(err), 0);
    check("clr_valid", int'(evt_valid), 0);
    x0 = n_xfer;
    step(1'b1, 4'd11);
    step(1'b1, 4'd10);
    step(1'b0, 4'd0);
    check("post_clr_sync_only", n_xfer - x0, 0);
    check("post_clr_err", int'(err), 0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/down_count_monitor.md
DOWN_COUNT_MONITOR -- requirements
Module: down_count_monitor

Interface
REQ-001 The block SHALL have parameter WRAP_W, default 8, giving the width of the wrap counter.
REQ-002 The block SHALL have input clk, 1 bit, the clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have input rst, 1 bit, the reset; reset rst, asynchronous, active-low; clock clk.
REQ-004 The block SHALL have input cnt_q, 4 bits, the sampled value of the upstream 4-bit down counter.
REQ-005 The block SHALL have input cnt_vld, 1 bit; cnt_q SHALL be sampled only in cycles where cnt_vld=1.
REQ-006 The block SHALL have input clr, 1 bit, a synchronous clear.
REQ-007 The block SHALL have input evt_ready, 1 bit, the consumer ready signal.
REQ-008 The block SHALL have outputs evt_valid (1 bit), evt_type (2 bits) and evt_data (4 bits), forming the event channel.
REQ-009 The block SHALL have outputs wrap_cnt (WRAP_W bits), err (1 bit, sticky), ovf (1 bit, sticky) and err_cnt (8 bits).

Function
REQ-010 The FSM SHALL have states SYNC, TRACK and STALL, and SHALL hold a 4-bit register prev.
REQ-011 In SYNC, on cnt_vld=1, the block SHALL set prev to cnt_q and move to TRACK with no event and no check.
REQ-012 The expected value SHALL be exp = (prev - 1) mod 16, so 0 is followed by 15.
REQ-013 In TRACK, when cnt_q=exp, the block SHALL set prev to cnt_q; if prev was 0, it SHALL raise a WRAP event (type 01, data 15) and increment wrap_cnt.
REQ-014 In TRACK, when cnt_q=prev, the block SHALL raise a STALL event (type 11, data cnt_q), move to STALL and leave prev unchanged.
REQ-015 In TRACK, for any other cnt_q, the block SHALL raise a SKIP event (type 10, data cnt_q), set err=1, set prev to cnt_q and stay in TRACK.
REQ-016 In STALL, cnt_q=prev SHALL produce no event; cnt_q=exp SHALL follow the REQ-013 rule (including WRAP) and move to TRACK; any other value SHALL follow the REQ-015 rule and move to TRACK.
REQ-017 Cycles with cnt_vld=0 SHALL change no state and raise no event.
REQ-018 An event SHALL appear on evt_valid/evt_type/evt_data exactly 1 cycle after the sampling edge (registered output).
REQ-019 The output slot SHALL hold 1 entry; the entry SHALL be transferred when evt_valid=1 and evt_ready=1.
REQ-020 When evt_valid=1, evt_type and evt_data SHALL stay stable until the entry is transferred.
REQ-021 If a new event occurs in the same cycle as a transfer, the new event SHALL load the slot and evt_valid SHALL stay 1.
REQ-022 If a new event occurs while evt_valid=1 and evt_ready=0, the new event SHALL be dropped and ovf SHALL be set to 1.
REQ-023 wrap_cnt SHALL saturate at all-ones.
REQ-024 clr=1 SHALL, in the next cycle, clear wrap_cnt, err, ovf, err_cnt and evt_valid and put the FSM in SYNC.
REQ-025 clr SHALL take priority over a cnt_vld sample in the same cycle; that sample SHALL be ignored.

Reset
REQ-026 While rst=0, the FSM SHALL be in SYNC and prev, evt_valid, evt_type, evt_data, wrap_cnt, err, ovf and err_cnt SHALL all be 0.
REQ-027 Reset SHALL take effect immediately, including in the middle of an event handshake; any pending event SHALL be lost.
REQ-028 The first cnt_vld sample after rst goes high SHALL be a SYNC sample only.

Configuration
REQ-029 With macro DCM_ERRCNT_EN defined, err_cnt SHALL count SKIP events, saturating at 255.
REQ-030 Without DCM_ERRCNT_EN, err_cnt SHALL be tied to 0 and no counter logic SHALL be built.

Structure
REQ-031 Package down_count_monitor_pkg SHALL hold the FSM state type, the event type codes (WRAP=01, SKIP=10, STALL=11) and a constant for the counter width (4).
REQ-032 The single-entry handshake output register SHALL be a sub-module named dcm_evt_slot.

Verification
REQ-033 After reset, feed 3,2,1,0,15,14 with cnt_vld=1 and evt_ready=1 -> exactly 1 WRAP event with data 15, wrap_cnt=1, err=0.
REQ-034 After sync at 5, feed 2 -> SKIP event with data 2 and err=1; then feed 1 -> no event.
REQ-035 After sync at 7, feed 7,7,6 -> exactly 1 STALL event with data 7, then no event, and the FSM is back in TRACK.
REQ-036 With evt_ready=0, cause a WRAP and then a SKIP -> the slot holds the WRAP event and ovf=1; after evt_ready=1, the WRAP event is transferred once.
REQ-037 With DCM_ERRCNT_EN defined, cause 300 SKIP events -> err_cnt=255; without the macro -> err_cnt=0.
REQ-038 Pull rst low with evt_valid=1, and separately assert clr during a sample -> all outputs are 0 or cleared, and the next sample is a SYNC sample only.
